// File: rtl/par_descrambler.sv
// par_descrambler: W-bit parallel descrambler for a SIGNAL / SERVICE / DATA framed bit stream.
// Optional feature: define PAR_DESCRAMBLER_PARITY_CHK_EN to check even parity over SIGNAL
// bits 0..17 and halt on failure; without it signal_err stays 0 and SIGNAL always proceeds.
module par_descrambler #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] data_in,
    input  logic         data_in_valid,
    output logic [W-1:0] data_out,
    output logic         data_out_valid,
    output logic [11:0]  length_out,
    output logic         frame_done,
    output logic         signal_err
);

    typedef enum logic [1:0] {
        ST_SIGNAL,
        ST_SERVICE,
        ST_DATA,
        ST_HALT
    } state_t;

    localparam logic [14:0] SIGNAL_BITS  = 15'd24;
    localparam logic [14:0] SERVICE_BITS = 15'd16;
    localparam logic [14:0] BEAT_BITS    = 15'(W);

    state_t       state;
    state_t       state_nxt;
    logic [14:0]  bit_cnt;
    logic [14:0]  bit_cnt_nxt;
    logic [14:0]  bit_cnt_plus;
    logic [14:0]  bit_idx;
    logic [14:0]  data_bits;
    logic [11:0]  len_cap;
    logic [11:0]  len_cap_nxt;
    logic [11:0]  length_nxt;
    logic [7:1]   scr;
    logic [7:1]   scr_nxt;
    logic         par_acc;
    logic         par_acc_nxt;
    logic [W-1:0] beat_out;
    logic [W-1:0] data_out_nxt;
    logic         valid_nxt;
    logic         done_nxt;
    logic         err_nxt;
    logic         fb;
    logic         beat_go;

    // Phase sequencing plus the per-bit datapath: each beat is unrolled into W single-bit steps
    // so that wide beats behave exactly like W consecutive serial bits.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        len_cap_nxt  = len_cap;
        length_nxt   = length_out;
        scr_nxt      = scr;
        par_acc_nxt  = par_acc;
        beat_out     = '0;
        bit_idx      = bit_cnt;
        fb           = 1'b0;
        data_out_nxt = data_out;
        valid_nxt    = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        bit_cnt_plus = bit_cnt + BEAT_BITS;
        data_bits    = {length_out, 3'b000};
        beat_go      = data_in_valid && (state != ST_HALT);

        if (beat_go) begin
            for (int i = 0; i < W; i++) begin
                bit_idx = bit_cnt + 15'(i);
                case (state)
                    ST_SIGNAL: begin
                        beat_out[i] = data_in[i];
                        if ((bit_idx >= 15'd5) && (bit_idx <= 15'd16)) begin
                            len_cap_nxt = {data_in[i], len_cap_nxt[11:1]};
                        end
                        if (bit_idx <= 15'd17) begin
                            par_acc_nxt = par_acc_nxt ^ data_in[i];
                        end
                    end
                    ST_SERVICE: begin
                        beat_out[i] = 1'b0;
                        scr_nxt     = {scr_nxt[6:1], data_in[i]};
                    end
                    ST_DATA: begin
                        fb          = scr_nxt[4] ^ scr_nxt[7];
                        beat_out[i] = data_in[i] ^ fb;
                        scr_nxt     = {scr_nxt[6:1], fb};
                    end
                    default: begin
                    end
                endcase
            end

            data_out_nxt = beat_out;
            valid_nxt    = 1'b1;
            bit_cnt_nxt  = bit_cnt_plus;

            case (state)
                ST_SIGNAL: begin
                    if (bit_cnt_plus == SIGNAL_BITS) begin
                        bit_cnt_nxt = '0;
`ifdef PAR_DESCRAMBLER_PARITY_CHK_EN
                        if (par_acc_nxt) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_HALT;
                        end else begin
                            length_nxt = len_cap_nxt;
                            state_nxt  = ST_SERVICE;
                        end
`else
                        length_nxt = len_cap_nxt;
                        state_nxt  = ST_SERVICE;
`endif
                        par_acc_nxt = 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bit_cnt_plus == SERVICE_BITS) begin
                        bit_cnt_nxt = '0;
                        if (length_out == 12'd0) begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_SIGNAL;
                        end else begin
                            state_nxt = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_plus == data_bits) begin
                        bit_cnt_nxt = '0;
                        done_nxt    = 1'b1;
                        state_nxt   = ST_SIGNAL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register; reset always returns to the start of a SIGNAL field.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_SIGNAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers; reset discards any frame in progress.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bit_cnt        <= '0;
            len_cap        <= '0;
            length_out     <= '0;
            scr            <= '0;
            par_acc        <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            signal_err     <= 1'b0;
        end else begin
            bit_cnt        <= bit_cnt_nxt;
            len_cap        <= len_cap_nxt;
            length_out     <= length_nxt;
            scr            <= scr_nxt;
            par_acc        <= par_acc_nxt;
            data_out       <= data_out_nxt;
            data_out_valid <= valid_nxt;
            frame_done     <= done_nxt;
            signal_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_par_descrambler.sv
// tb_par_descrambler: checks par_descrambler at W=1, W=4 and W=8 against a bit-stream model.
`timescale 1ns/1ps
module tb_par_descrambler;

`ifdef PAR_DESCRAMBLER_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;

    // Free-running clock shared by all three instances
    always #5 clk = ~clk;

    logic        rst1, rst4, rst8;
    logic        vin1, vin4, vin8;
    logic [0:0]  din1, dout1;
    logic [3:0]  din4, dout4;
    logic [7:0]  din8, dout8;
    logic        vo1, vo4, vo8;
    logic        fd1, fd4, fd8;
    logic        se1, se4, se8;
    logic [11:0] lo1, lo4, lo8;

    par_descrambler #(.W(1)) dut1 (
        .Clk(clk), .Reset(rst1), .data_in(din1), .data_in_valid(vin1),
        .data_out(dout1), .data_out_valid(vo1), .length_out(lo1),
        .frame_done(fd1), .signal_err(se1)
    );
    par_descrambler #(.W(4)) dut4 (
        .Clk(clk), .Reset(rst4), .data_in(din4), .data_in_valid(vin4),
        .data_out(dout4), .data_out_valid(vo4), .length_out(lo4),
        .frame_done(fd4), .signal_err(se4)
    );
    par_descrambler #(.W(8)) dut8 (
        .Clk(clk), .Reset(rst8), .data_in(din8), .data_in_valid(vin8),
        .data_out(dout8), .data_out_valid(vo8), .length_out(lo8),
        .frame_done(fd8), .signal_err(se8)
    );

    typedef struct {
        bit          rst;
        bit          dead;
        bit          air;
        bit          outb;
        bit          done;
        bit          err;
        logic [11:0] len;
    } rec_t;

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        ev;
        logic [7:0]  ed;
        logic        edone;
        logic [11:0] elen;
    } vec_t;

    rec_t        stream[$];
    logic [11:0] m_len  = '0;
    bit          m_halt = 1'b0;
    logic [7:0]  held_d [3] = '{8'h00, 8'h00, 8'h00};
    logic [11:0] cur_len[3] = '{12'd0, 12'd0, 12'd0};
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[14];

    function automatic int laneW(input int lane);
        return (lane == 0) ? 1 : ((lane == 1) ? 4 : 8);
    endfunction

    task automatic driveLane(input int lane, input logic rst, input logic v, input logic [7:0] d);
        case (lane)
            0:       begin rst1 = rst; vin1 = v; din1 = d[0:0]; end
            1:       begin rst4 = rst; vin4 = v; din4 = d[3:0]; end
            default: begin rst8 = rst; vin8 = v; din8 = d;      end
        endcase
    endtask

    task automatic compareVal(input string name, input int lane, input logic [11:0] act,
                              input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s lane W=%0d: got %0h expected %0h at %0t",
                     name, laneW(lane), act, exp, $time);
        end
    endtask

    task automatic checkOutput(input int lane, input logic ev, input logic [7:0] ed,
                               input logic edone, input logic eerr, input logic [11:0] elen);
        logic        v, fd, se;
        logic [7:0]  d;
        logic [11:0] l;
        case (lane)
            0:       begin v = vo1; d = {7'b0, dout1}; fd = fd1; se = se1; l = lo1; end
            1:       begin v = vo4; d = {4'b0, dout4}; fd = fd4; se = se4; l = lo4; end
            default: begin v = vo8; d = dout8;         fd = fd8; se = se8; l = lo8; end
        endcase
        compareVal("data_out_valid", lane, {11'b0, v},  {11'b0, ev});
        compareVal("data_out",       lane, {4'b0, d},   {4'b0, ed});
        compareVal("frame_done",     lane, {11'b0, fd}, {11'b0, edone});
        compareVal("signal_err",     lane, {11'b0, se}, {11'b0, eerr});
        compareVal("length_out",     lane, l,           elen);
    endtask

    task automatic push_bit(input bit air, input bit outb, input bit done, input bit err);
        rec_t r;
        r.rst  = 1'b0;
        r.dead = m_halt;
        r.air  = air;
        r.outb = outb;
        r.done = done;
        r.err  = err;
        r.len  = m_len;
        stream.push_back(r);
    endtask

    task automatic push_reset();
        rec_t r;
        r.rst  = 1'b1;
        r.dead = 1'b0;
        r.air  = 1'b0;
        r.outb = 1'b0;
        r.done = 1'b0;
        r.err  = 1'b0;
        r.len  = 12'd0;
        stream.push_back(r);
        m_len  = '0;
        m_halt = 1'b0;
    endtask

    // Builds one frame as a bit list on air plus the bits expected out. The DATA keystream is
    // the sequence recurrence k[n] = x[n-4] ^ x[n-7] over service bits followed by keystream.
    task automatic build_frame(input logic [11:0] len, input bit corrupt, input bit seeded,
                               input bit zero_plain, input int trunc_at);
        bit         sig[24];
        bit         svc[16];
        bit         hist[$];
        bit         par, k, p;
        logic [6:0] seed;
        int         nbits;
        seed  = 7'b1011101;
        nbits = int'(len) * 8;
        for (int i = 0; i < 24; i++) sig[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 12; i++) sig[5 + i] = len[i];
        par = 1'b0;
        for (int i = 0; i < 17; i++) par = par ^ sig[i];
        sig[17] = par ^ corrupt;
        for (int i = 0; i < 24; i++) begin
            if (i == 23) begin
                if (corrupt && PAR_EN) begin
                    push_bit(sig[i], sig[i], 1'b0, 1'b1);
                    m_halt = 1'b1;
                end else begin
                    if (!m_halt) m_len = len;
                    push_bit(sig[i], sig[i], 1'b0, 1'b0);
                end
            end else begin
                push_bit(sig[i], sig[i], 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (seeded) svc[i] = (i >= 9) ? seed[i - 9] : 1'b0;
            else        svc[i] = 1'($urandom_range(0, 1));
            push_bit(svc[i], 1'b0, (len == 12'd0) && (i == 15), 1'b0);
            hist.push_back(svc[i]);
        end
        for (int j = 0; j < nbits; j++) begin
            if (j == trunc_at) begin
                push_reset();
                return;
            end
            k = hist[$-3] ^ hist[$-6];
            hist.push_back(k);
            p = zero_plain ? 1'b0 : 1'($urandom_range(0, 1));
            push_bit(p ^ k, p, j == nbits - 1, 1'b0);
        end
    endtask

    // Plays the queued bit stream into one lane, beat by beat, optionally with idle gaps.
    task automatic applyStimulus(input int lane, input bit gaps);
        int          idx;
        int          lw;
        logic [7:0]  air, exp_d;
        logic        exp_done, exp_err, dead;
        logic [11:0] exp_len;
        idx = 0;
        lw  = laneW(lane);
        while (idx < stream.size()) begin
            if (stream[idx].rst) begin
                driveLane(lane, 1'b0, 1'b0, 8'($urandom));
                @(posedge clk); #1;
                checkOutput(lane, 1'b0, 8'h00, 1'b0, 1'b0, 12'd0);
                held_d[lane]  = '0;
                cur_len[lane] = '0;
                idx++;
            end else if (idx + lw > stream.size()) begin
                break;
            end else begin
                air      = '0;
                exp_d    = '0;
                exp_done = 1'b0;
                exp_err  = 1'b0;
                dead     = stream[idx].dead;
                exp_len  = stream[idx + lw - 1].len;
                for (int b = 0; b < lw; b++) begin
                    air[b]   = stream[idx + b].air;
                    exp_d[b] = stream[idx + b].outb;
                    exp_done = exp_done | stream[idx + b].done;
                    exp_err  = exp_err | stream[idx + b].err;
                end
                idx += lw;
                driveLane(lane, 1'b1, 1'b1, air);
                @(posedge clk); #1;
                if (dead) begin
                    checkOutput(lane, 1'b0, held_d[lane], 1'b0, 1'b0, cur_len[lane]);
                end else begin
                    checkOutput(lane, 1'b1, exp_d, exp_done, exp_err, exp_len);
                    held_d[lane]  = exp_d;
                    cur_len[lane] = exp_len;
                end
                if (gaps) begin
                    driveLane(lane, 1'b1, 1'b0, 8'($urandom));
                    @(posedge clk); #1;
                    checkOutput(lane, 1'b0, held_d[lane], 1'b0, 1'b0, cur_len[lane]);
                end
            end
        end
        driveLane(lane, 1'b1, 1'b0, 8'h00);
        stream.delete();
    endtask

    // Safety net so the run always ends on its own
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence: reset, W=8 vector table, then model-driven frames on each width
    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 12'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'h0B, 1'b1, 8'h0B, 1'b0, 12'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 12'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'h02, 1'b1, 8'h02, 1'b0, 12'd0};
        vecs[4]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 12'd0};
        vecs[5]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'h00, 1'b1, 12'd0};
        vecs[6]  = '{1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 12'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'h77, 1'b0, 8'h20, 1'b0, 12'd0};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 12'd0};
        vecs[9]  = '{1'b1, 1'b1, 8'h02, 1'b1, 8'h02, 1'b0, 12'd1};
        vecs[10] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 12'd1};
        vecs[11] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 12'd1};
        vecs[12] = '{1'b1, 1'b1, 8'h2A, 1'b1, 8'h5A, 1'b1, 12'd1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 12'd1};

        driveLane(0, 1'b0, 1'b0, 8'h00);
        driveLane(1, 1'b0, 1'b0, 8'h00);
        driveLane(2, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput(0, 1'b0, 8'h00, 1'b0, 1'b0, 12'd0);
        checkOutput(1, 1'b0, 8'h00, 1'b0, 1'b0, 12'd0);

        $display("[TB] W=8 vector table");
        for (int r = 0; r < 14; r++) begin
            driveLane(2, vecs[r].rst, vecs[r].v, vecs[r].d);
            @(posedge clk); #1;
            checkOutput(2, vecs[r].ev, vecs[r].ed, vecs[r].edone, 1'b0, vecs[r].elen);
        end
        driveLane(2, 1'b1, 1'b0, 8'h00);

        $display("[TB] seeded LENGTH=2 frame, W=1 and W=8");
        push_reset(); build_frame(12'd2, 1'b0, 1'b1, 1'b1, -1); applyStimulus(0, 1'b0);
        push_reset(); build_frame(12'd2, 1'b0, 1'b1, 1'b1, -1); applyStimulus(2, 1'b0);

        $display("[TB] W=4 LENGTH=1 gapless and with alternating valid");
        push_reset(); build_frame(12'd1, 1'b0, 1'b0, 1'b0, -1); applyStimulus(1, 1'b0);
        push_reset(); build_frame(12'd1, 1'b0, 1'b0, 1'b0, -1); applyStimulus(1, 1'b1);

        $display("[TB] LENGTH=0 then LENGTH=1 back to back");
        for (int lane = 0; lane < 3; lane++) begin
            push_reset();
            build_frame(12'd0, 1'b0, 1'b0, 1'b0, -1);
            build_frame(12'd1, 1'b0, 1'b0, 1'b0, -1);
            applyStimulus(lane, 1'b0);
        end

        $display("[TB] SIGNAL parity corruption then recovery");
        for (int lane = 0; lane < 3; lane += 2) begin
            push_reset();
            build_frame(12'd2, 1'b1, 1'b0, 1'b0, -1);
            build_frame(12'd1, 1'b0, 1'b0, 1'b0, -1);
            push_reset();
            build_frame(12'd1, 1'b0, 1'b0, 1'b0, -1);
            applyStimulus(lane, 1'b0);
        end

        $display("[TB] reset during DATA of LENGTH=4 frame");
        for (int lane = 0; lane < 3; lane++) begin
            push_reset();
            build_frame(12'd4, 1'b0, 1'b0, 1'b0, (10 / laneW(lane)) * laneW(lane));
            build_frame(12'd2, 1'b0, 1'b0, 1'b0, -1);
            applyStimulus(lane, 1'b0);
        end

        $display("[TB] random frames");
        for (int lane = 0; lane < 3; lane++) begin
            push_reset();
            for (int f = 0; f < 4; f++) begin
                build_frame(12'($urandom_range(0, 5)), 1'b0, 1'b0, 1'b0, -1);
            end
            applyStimulus(lane, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par_descrambler.md
PAR_DESCRAMBLER -- requirements
Module: par_descrambler

Interface
REQ-001 Parameter W, default 1: bits per beat; legal values 1, 2, 4, 8 only.
REQ-002 Clk  input  1  single clock; all logic on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 data_in  input  W  received bits; data_in[0] is the earliest bit on air.
REQ-005 data_in_valid  input  1  beat qualifier; no back-pressure, every valid beat is consumed.
REQ-006 data_out  output  W  descrambled/pass-through bits, same bit order as data_in.
REQ-007 data_out_valid  output  1  qualifies data_out.
REQ-008 length_out  output  12  LENGTH field (bytes) of the current frame.
REQ-009 frame_done  output  1  one-cycle pulse coincident with the last DATA beat on data_out.
REQ-010 signal_err  output  1  one-cycle SIGNAL parity-failure pulse (see Configuration).

Function
REQ-011 Block SHALL hold a 15-bit beat-independent bit counter, a 12-bit length register, a 7-bit scrambler state s[1:7] and a state machine {SIGNAL, SERVICE, DATA, HALT}.
REQ-012 All outputs SHALL be registered; latency data_in to data_out SHALL be exactly 1 cycle.
REQ-013 Beats with data_in_valid=0 SHALL not advance counter, state or s; data_out_valid SHALL be 0 the following cycle, data_out held.
REQ-014 SIGNAL: 24 bits (24/W beats); data_out = data_in, data_out_valid=1; SIGNAL bits 5..16 SHALL be captured LSB-first into length.
REQ-015 After SIGNAL bit 23, length_out SHALL update with the captured value in the same cycle the last SIGNAL beat appears on data_out; state SHALL go to SERVICE, counter to 0.
REQ-016 SERVICE: 16 bits; data_out SHALL be all-zero with data_out_valid=1; each received bit SHALL shift into s (s[1] <= bit, s[2:7] <= s[1:6]), in bit order within a beat.
REQ-017 After 16 SERVICE bits, state SHALL go to DATA if length != 0, else directly to SIGNAL with frame_done pulsed on the last SERVICE beat.
REQ-018 DATA: length*8 bits; per bit in order, f = s[4] ^ s[7], out bit = in bit ^ f, s[1] <= f, s[2:7] <= s[1:6]; W-bit beats SHALL equal W sequential single-bit steps.
REQ-019 Counter compare for DATA end SHALL use {length, 3'b000} in 15-bit arithmetic; max 32760 bits without overflow.
REQ-020 On the last DATA beat, frame_done SHALL pulse and state SHALL return to SIGNAL with counter 0, ready for a back-to-back frame on the next valid beat.
REQ-021 HALT: data_out_valid SHALL stay 0 regardless of data_in_valid until Reset.
REQ-022 frame_done and signal_err SHALL never be asserted while data_out_valid is 0.

Reset
REQ-023 Reset=0 at a rising edge SHALL set state=SIGNAL, counter=0, data_out_valid=0, frame_done=0, signal_err=0, data_out=0, length_out=0, s=0.
REQ-024 Reset mid-frame SHALL discard the frame; no frame_done SHALL be emitted for it.

Configuration
REQ-025 Macro PAR_DESCRAMBLER_PARITY_CHK_EN SHALL, when defined, check even parity over SIGNAL bits 0..17 at end of SIGNAL.
REQ-026 With macro defined, parity failure SHALL pulse signal_err with the last SIGNAL beat output, leave length_out unchanged, and enter HALT.
REQ-027 Without macro, signal_err SHALL be constant 0 and SIGNAL SHALL always proceed to SERVICE.

Verification
REQ-028 W=1, SIGNAL with LENGTH=2, SERVICE scrambled from seed 7'b1011101, 16 zero data bits scrambled -> data_out all-zero for DATA, frame_done on bit 15, length_out=2.
REQ-029 W=8, same frame -> byte-wise identical output to W=1 run; 3+2+2 beats; frame_done on 7th output beat.
REQ-030 W=4, valid toggling 1/0 every cycle through a LENGTH=1 frame -> output matches gapless run, data_out_valid mirrors input gaps with 1-cycle delay.
REQ-031 LENGTH=0 frame followed immediately by LENGTH=1 frame -> frame_done on last SERVICE beat of frame 1, second frame decoded correctly.
REQ-032 Macro defined, SIGNAL with flipped parity bit 17 -> signal_err pulse, no further data_out_valid until Reset; macro undefined -> frame decoded normally.
REQ-033 Reset=0 asserted at DATA bit 10 of LENGTH=4 frame -> outputs zeroed next cycle, no frame_done, next frame decoded from SIGNAL.
